pipeline_hazard_sequencer: RTL

Central pipeline controller for the three-stage CPU (IF, ID, EX/WB). It is the only block that drives the PC write-enable, the IF/ID hold and flush signals, and the bubble insertion into ID/EX and EX/WB. It detects read-after-write hazards in ID, squashes wrong-path instructions when PCControl redirects the PC, and runs a halt/drain/resume sequence. It keeps internal valid bits for each pipeline register and exposes stall and flush performance counters.

---
 rtl/cpu_pkg.sv | 30 +++
 rtl/pipeline_hazard_sequencer_if.sv | 48 ++++
 rtl/sat_counter.sv | 19 +
 rtl/pipeline_hazard_sequencer.sv | 118 +++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction field layout, operand widths and the
// pipeline sequencer state encoding.
package cpu_pkg;

  localparam int unsigned OPC_W = 4;
  localparam int unsigned REG_W = 6;

  localparam int unsigned OPC_HI = 31;
  localparam int unsigned OPC_LO = 28;
  localparam int unsigned RD_HI  = 27;
  localparam int unsigned RD_LO  = 22;
  localparam int unsigned RS_HI  = 21;
  localparam int unsigned RS_LO  = 16;
  localparam int unsigned RT_HI  = 15;
  localparam int unsigned RT_LO  = 10;

  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_DRAIN  = 2'b01,
    ST_HALTED = 2'b10
  } seq_state_t;

  // True when an operand field is read and names the producer's destination.
  function automatic logic src_hit(input logic used,
                                   input logic [REG_W-1:0] src,
                                   input logic [REG_W-1:0] dst);
    return used && (src == dst);
  endfunction

endpackage

// File: rtl/pipeline_hazard_sequencer_if.sv
// Pipeline-control bundle between the datapath (master) and the hazard
// sequencer (slave).
interface pipeline_hazard_sequencer_if #(
  parameter int unsigned CNT_W = 16
);
  import cpu_pkg::*;

  logic [OPC_W-1:0] in_id_opcode;
  logic [REG_W-1:0] in_id_rs;
  logic [REG_W-1:0] in_id_rt;
  logic             in_idex_regwrt;
  logic [REG_W-1:0] in_idex_rd;
  logic             in_exwb_regwrt;
  logic [REG_W-1:0] in_exwb_rd;
  logic             in_redirect;
  logic             in_halt_req;
  logic             in_resume;

  logic             out_pc_write;
  logic             out_ifid_write;
  logic             out_ifid_flush;
  logic             out_idex_bubble;
  logic             out_exwb_bubble;
  logic             out_mem_kill;
  logic             out_halted;
  logic [1:0]       out_state;
  logic [CNT_W-1:0] out_stall_count;
  logic [CNT_W-1:0] out_flush_count;

  modport master (
    output in_id_opcode, in_id_rs, in_id_rt,
    output in_idex_regwrt, in_idex_rd, in_exwb_regwrt, in_exwb_rd,
    output in_redirect, in_halt_req, in_resume,
    input  out_pc_write, out_ifid_write, out_ifid_flush,
    input  out_idex_bubble, out_exwb_bubble, out_mem_kill,
    input  out_halted, out_state, out_stall_count, out_flush_count
  );

  modport slave (
    input  in_id_opcode, in_id_rs, in_id_rt,
    input  in_idex_regwrt, in_idex_rd, in_exwb_regwrt, in_exwb_rd,
    input  in_redirect, in_halt_req, in_resume,
    output out_pc_write, out_ifid_write, out_ifid_flush,
    output out_idex_bubble, out_exwb_bubble, out_mem_kill,
    output out_halted, out_state, out_stall_count, out_flush_count
  );

endinterface

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that sticks at its maximum value.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_hazard_sequencer.sv
// Central controller for the IF/ID/EX-WB pipeline: RAW stalls, redirect
// squashing, halt/drain/resume sequencing and stall/flush counters.
module pipeline_hazard_sequencer
  import cpu_pkg::*;
#(
  parameter logic [15:0] RS_USE_MASK = 16'hFFFF,
  parameter logic [15:0] RT_USE_MASK = 16'hFFFF,
  parameter bit          WB_BYPASS   = 1'b0,
  parameter int unsigned CNT_W       = 16
) (
  input  logic clk,
  input  logic reset,
  pipeline_hazard_sequencer_if.slave bus
);

  seq_state_t state, state_nxt;
  logic v_ifid, v_idex, v_exwb;
  logic rs_used, rt_used, haz_ex, haz_wb, redir, stall;
  logic pc_write, ifid_write, ifid_flush, idex_bubble, exwb_bubble, mem_kill;

  always_comb begin
    rs_used = RS_USE_MASK[bus.in_id_opcode];
    rt_used = RT_USE_MASK[bus.in_id_opcode];
    redir   = bus.in_redirect & v_exwb;
    haz_ex  = v_ifid & v_idex & bus.in_idex_regwrt &
              (src_hit(rs_used, bus.in_id_rs, bus.in_idex_rd) |
               src_hit(rt_used, bus.in_id_rt, bus.in_idex_rd));
    haz_wb  = !WB_BYPASS & v_ifid & v_exwb & bus.in_exwb_regwrt &
              (src_hit(rs_used, bus.in_id_rs, bus.in_exwb_rd) |
               src_hit(rt_used, bus.in_id_rt, bus.in_exwb_rd));
    stall   = (haz_ex | haz_wb) & ~redir & (state != ST_HALTED);
  end

  // A stall holds IF/ID rather than flushing it, so a DRAIN-time stall keeps
  // the waiting instruction instead of losing it.
  always_comb begin
    pc_write    = 1'b0;
    ifid_write  = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    exwb_bubble = 1'b0;
    mem_kill    = 1'b0;
    if (reset) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      exwb_bubble = 1'b1;
      mem_kill    = 1'b1;
    end else if (redir) begin
      pc_write    = 1'b1;
      ifid_write  = 1'b1;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      exwb_bubble = 1'b1;
      mem_kill    = 1'b1;
    end else if (stall) begin
      idex_bubble = 1'b1;
    end else begin
      unique case (state)
        ST_RUN: begin
          pc_write   = 1'b1;
          ifid_write = 1'b1;
        end
        ST_DRAIN: begin
          ifid_write = 1'b1;
          ifid_flush = 1'b1;
        end
        default: ifid_flush = 1'b1;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_RUN:   if (bus.in_halt_req) state_nxt = ST_DRAIN;
      ST_DRAIN: if (!(v_ifid | v_idex | v_exwb)) state_nxt = ST_HALTED;
      default:  if (bus.in_resume) state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_RUN;
      v_ifid <= 1'b0;
      v_idex <= 1'b0;
      v_exwb <= 1'b0;
    end else begin
      state  <= state_nxt;
      v_ifid <= ifid_flush ? 1'b0 : (ifid_write ? (state == ST_RUN) : v_ifid);
      v_idex <= idex_bubble ? 1'b0 : v_ifid;
      v_exwb <= exwb_bubble ? 1'b0 : v_idex;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .clr   (reset),
    .inc   (stall),
    .count (bus.out_stall_count)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .clr   (reset),
    .inc   (redir),
    .count (bus.out_flush_count)
  );

  assign bus.out_pc_write    = pc_write;
  assign bus.out_ifid_write  = ifid_write;
  assign bus.out_ifid_flush  = ifid_flush;
  assign bus.out_idex_bubble = idex_bubble;
  assign bus.out_exwb_bubble = exwb_bubble;
  assign bus.out_mem_kill    = mem_kill;
  assign bus.out_halted      = (state == ST_HALTED);
  assign bus.out_state       = state;

endmodule
